uart_tx: RTL

//   Serial UART transmitter, the outgoing counterpart of the UART receiver. Takes bytes over a

---
 rtl/uart_tx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-stream UART transmitter with a small FIFO and bus-configured baud rate and frame format
`timescale 1ns/1ps
module uart_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       c_valid,
    input  logic [3:0] c_addr,
    input  logic [7:0] c_data,
    output logic       c_ready,
    output logic       tx,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_9600   = 16'(CLK_FREQ / 9600);
    localparam logic [15:0] DIV_19200  = 16'(CLK_FREQ / 19200);
    localparam logic [15:0] DIV_38400  = 16'(CLK_FREQ / 38400);
    localparam logic [15:0] DIV_57600  = 16'(CLK_FREQ / 57600);
    localparam logic [15:0] DIV_115200 = 16'(CLK_FREQ / 115200);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_nx;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic [2:0]    baud_sel;
    logic          parity_en, parity_odd, two_stop;
    logic [15:0]   div_q, div_sel, cnt;
    logic          par_en_q, two_stop_q, par_bit, stop_idx;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic          push, pop, tick, cfg_we, empty;

    assign empty    = count == '0;
    assign in_ready = count != (AW+1)'(FIFO_DEPTH);
    assign c_ready  = state == IDLE && empty;
    assign busy     = state != IDLE || !empty;
    assign push     = in_valid && in_ready;
    assign cfg_we   = c_valid && c_ready;
    assign tick     = cnt == div_q - 16'd1;
    assign div_sel  = baud_sel == 3'd1 ? DIV_19200 :
                      baud_sel == 3'd2 ? DIV_38400 :
                      baud_sel == 3'd3 ? DIV_57600 :
                      baud_sel == 3'd4 ? DIV_115200 : DIV_9600;

    // FIFO storage: no reset needed, validity is tracked by count
    always_ff @(posedge clk)
        if (push) mem[wp] <= in_data;

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end

    // configuration registers, writable only while idle with nothing queued
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            baud_sel                           <= 3'd4;
            {two_stop, parity_odd, parity_en} <= 3'b000;
        end else begin
            if (cfg_we && c_addr == 4'hC) baud_sel <= c_data[2:0];
            if (cfg_we && c_addr == 4'hD) {two_stop, parity_odd, parity_en} <= c_data[2:0];
        end

    // next state and FIFO pop; a STOP that finds more data chains straight into START
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE:    if (!empty) begin
                         pop      = 1'b1;
                         state_nx = START;
                     end
            START:   if (tick) state_nx = DATA;
            DATA:    if (tick && bit_idx == 3'd7) state_nx = par_en_q ? PARITY : STOP;
            PARITY:  if (tick) state_nx = STOP;
            STOP:    if (tick && stop_idx == two_stop_q) begin
                         pop      = !empty;
                         state_nx = empty ? IDLE : START;
                     end
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    // bit timing, shifter and registered line; frame format is captured when a byte is popped
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt        <= '0;
            div_q      <= DIV_115200;
            shift      <= '0;
            par_bit    <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            tx         <= 1'b1;
        end else begin
            cnt <= (state == IDLE || tick) ? 16'd0 : cnt + 16'd1;
            if (pop) begin
                shift      <= mem[rp];
                par_bit    <= ^mem[rp] ^ parity_odd;
                div_q      <= div_sel;
                par_en_q   <= parity_en;
                two_stop_q <= two_stop;
                bit_idx    <= '0;
                stop_idx   <= 1'b0;
            end else if (tick) begin
                if (state == DATA) begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
                if (state == STOP) stop_idx <= ~stop_idx;
            end
            tx <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_bit : 1'b1;
        end
endmodule
